aes128_iter_encrypt: RTL and testbench



---
 rtl/aes128_iter_encrypt.sv | 180 ++++++++++++++++++
 tb/tb_aes128_iter_encrypt.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_encrypt.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Optional completed-block counter enabled by defining AES_ENC_BLKCNT_EN.
module aes128_iter_encrypt (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
`ifdef AES_ENC_BLKCNT_EN
  output logic [15:0]  blocks_done,
`endif
  output logic         busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box computed as GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  // Byte b sits at [127-8b -: 8]; row = b%4, column = b/4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int b = 0; b < 16; b++) begin
      src = (b % 4) + 4 * (((b / 4) + (b % 4)) % 4);
      o[127-8*b -: 8] = sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  logic [1:0]   fsm_q, fsm_d;
  logic [127:0] state_q, state_d, rk_q, rk_d, ct_q, ct_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         ov_q, ov_d;
  logic [31:0]  rot_w, sub_w, w0n, w1n, w2n, w3n;
  logic [127:0] rk_next;
`ifdef AES_ENC_BLKCNT_EN
  logic [15:0]  cnt_q, cnt_d;
`endif

  always_comb begin
    rot_w   = {rk_q[23:0], rk_q[31:24]};
    sub_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    w0n     = rk_q[127:96] ^ sub_w ^ {rcon_q, 24'h0};
    w1n     = rk_q[95:64] ^ w0n;
    w2n     = rk_q[63:32] ^ w1n;
    w3n     = rk_q[31:0] ^ w2n;
    rk_next = {w0n, w1n, w2n, w3n};
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    rnd_d   = rnd_q;
    ct_d    = ct_q;
    ov_d    = ov_q;
`ifdef AES_ENC_BLKCNT_EN
    cnt_d   = cnt_q;
`endif
    case (fsm_q)
      IDLE: if (in_valid) begin
        state_d = plaintext ^ key;
        rk_d    = key;
        rcon_d  = 8'h01;
        rnd_d   = 4'd1;
        fsm_d   = ROUND;
      end
      ROUND: begin
        state_d = mix(sub_shift(state_q)) ^ rk_next;
        rk_d    = rk_next;
        rcon_d  = xtime(rcon_q);
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == 4'd9) fsm_d = FINAL;
      end
      FINAL: begin
        ct_d  = sub_shift(state_q) ^ rk_next;
        rk_d  = rk_next;
        ov_d  = 1'b1;
        fsm_d = HOLD;
      end
      HOLD: if (out_ready) begin
        ov_d  = 1'b0;
        fsm_d = IDLE;
`ifdef AES_ENC_BLKCNT_EN
        cnt_d = cnt_q + 16'd1;
`endif
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rcon_q  <= 8'h01;
      rnd_q   <= '0;
      ct_q    <= '0;
      ov_q    <= 1'b0;
`ifdef AES_ENC_BLKCNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      rnd_q   <= rnd_d;
      ct_q    <= ct_d;
      ov_q    <= ov_d;
`ifdef AES_ENC_BLKCNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign in_ready   = (fsm_q == IDLE);
  assign busy       = (fsm_q == ROUND) || (fsm_q == FINAL);
  assign out_valid  = ov_q;
  assign ciphertext = ct_q;
`ifdef AES_ENC_BLKCNT_EN
  assign blocks_done = cnt_q;
`endif
endmodule

// File: tb/tb_aes128_iter_encrypt.sv
// Directed bench for aes128_iter_encrypt using FIPS-197 known-answer vectors.
module tb_aes128_iter_encrypt;
  logic         clk = 1'b0;
  logic         reset, in_valid, out_ready;
  logic [127:0] plaintext, key;
  logic         in_ready, out_valid, busy;
  logic [127:0] ciphertext;
`ifdef AES_ENC_BLKCNT_EN
  logic [15:0]  blocks_done;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_P   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_C   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes128_iter_encrypt dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext),
`ifdef AES_ENC_BLKCNT_EN
    .blocks_done(blocks_done),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts one block, then scrambles the input buses right after the accept edge.
  task automatic start(input logic [127:0] p, input logic [127:0] k);
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    key       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic finish_block(input string tag, input logic [127:0] exp);
    repeat (9) step();
    chk({tag, "_ov_e9"}, 128'(out_valid), 128'd0);
    chk({tag, "_busy_e9"}, 128'(busy), 128'd1);
    step();
    chk({tag, "_ov_e10"}, 128'(out_valid), 128'd1);
    chk({tag, "_ct"}, ciphertext, exp);
  endtask

  initial begin
    logic [127:0] pts[3], kys[3], cts[3];
    logic [127:0] held;
    int nacc, nout, last, both;
    pts = '{C1_P, B_P, C1_P};
    kys = '{C1_K, B_K, C1_K};
    cts = '{C1_C, B_C, C1_C};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_ct", ciphertext, 128'd0);
`ifdef AES_ENC_BLKCNT_EN
    chk("rst_cnt", 128'(blocks_done), 128'd0);
`endif

    // C.1 with buses changed after accept, then held under backpressure.
    start(C1_P, C1_K);
    finish_block("c1", C1_C);
    held = ciphertext;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_ct", ciphertext, held);
      chk("bp_ov", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_rel_in_ready", 128'(in_ready), 128'd1);
    chk("bp_rel_ov", 128'(out_valid), 128'd0);
    out_ready = 1'b0;

    start(B_P, B_K);
    finish_block("b", B_C);
    chk("b_rk10", dut.rk_q, B_RK);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`ifdef AES_ENC_BLKCNT_EN
    chk("cnt_two", 128'(blocks_done), 128'd2);
`endif

    // Reset after round 5 discards the block.
    start(C1_P, C1_K);
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_ov", 128'(out_valid), 128'd0);
    chk("mr_in_ready", 128'(in_ready), 128'd1);
    chk("mr_busy", 128'(busy), 128'd0);
    chk("mr_ct", ciphertext, 128'd0);
    start(C1_P, C1_K);
    finish_block("mr_c1", C1_C);
    out_ready = 1'b1;
    step();

    // Back-to-back blocks with out_ready held high.
    reset = 1'b1;
    step();
    reset = 1'b0;
    nacc = 0; nout = 0; last = -1; both = 0;
    for (int cyc = 0; cyc < 80 && nout < 3; cyc++) begin
      in_valid  = (nacc < 3);
      plaintext = pts[nacc < 3 ? nacc : 0];
      key       = kys[nacc < 3 ? nacc : 0];
      if (in_ready && out_valid) both++;
      if (out_valid) begin
        chk("b2b_ct", ciphertext, cts[nout]);
        nout++;
      end
      if (in_ready && in_valid) begin
        if (nacc > 0) chk("b2b_gap", 128'(cyc - last), 128'd12);
        last = cyc;
        nacc++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("b2b_nout", 128'(nout), 128'd3);
    chk("b2b_rdy_vld_excl", 128'(both), 128'd0);
`ifdef AES_ENC_BLKCNT_EN
    chk("b2b_cnt", 128'(blocks_done), 128'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
